// File: rtl/ctrl_pkg.sv
// Shared definitions for the accumulator-CPU control sequencer: opcodes,
// T-state encoding and control-word bit positions.
package ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_JNC = 4'h9;
    localparam logic [3:0] OP_JNZ = 4'hA;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_e;

    localparam int CW_W          = 15;
    localparam int CW_PC_INC     = 14;
    localparam int CW_PC_LOAD    = 13;
    localparam int CW_PC_OUT     = 12;
    localparam int CW_MAR_LOAD   = 11;
    localparam int CW_RAM_OUT    = 10;
    localparam int CW_RAM_WE     = 9;
    localparam int CW_IR_LOAD    = 8;
    localparam int CW_IR_OUT     = 7;
    localparam int CW_A_LOAD     = 6;
    localparam int CW_A_OUT      = 5;
    localparam int CW_B_LOAD     = 4;
    localparam int CW_ALU_OUT    = 3;
    localparam int CW_ALU_SUB    = 2;
    localparam int CW_FLAGS_LOAD = 1;
    localparam int CW_OUT_LOAD   = 0;

    typedef logic [CW_W-1:0] cw_t;

    function automatic cw_t cw_bit(input int idx);
        return cw_t'(1) << idx;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational decode of (opcode, T-state, flags) into the control word.
// Optional macro CTRL_EXT_JUMPS_EN adds JNC (0x9) and JNZ (0xA).
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W      = 4,
    parameter bit HALT_ON_UNDEF = 1'b0
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  tstate_e             tstate,
    input  logic                cf,
    input  logic                zf,
    output cw_t                 cw,
    output logic                last_step,
    output logic                enter_halt
);

    logic [3:0] op;
    logic       is_sub;

    assign op     = opcode[3:0];
    assign is_sub = (op == OP_SUB);

    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        cw         = '0;
        last_step  = 1'b0;
        enter_halt = 1'b0;
        case (tstate)
            T0: cw = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_LOAD);
            T1: cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_LOAD) | cw_bit(CW_PC_INC);
            default: begin
                case (op)
                    OP_NOP: last_step = 1'b1;
                    OP_LDA: begin
                        if (tstate == T2) begin
                            cw = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
                        end else begin
                            cw        = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_LOAD);
                            last_step = 1'b1;
                        end
                    end
                    OP_ADD, OP_SUB: begin
                        if (tstate == T2) begin
                            cw = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
                        end else if (tstate == T3) begin
                            cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_LOAD)
                               | (is_sub ? cw_bit(CW_ALU_SUB) : '0);
                        end else begin
                            cw = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LOAD) | cw_bit(CW_FLAGS_LOAD)
                               | (is_sub ? cw_bit(CW_ALU_SUB) : '0);
                            last_step = 1'b1;
                        end
                    end
                    OP_STA: begin
                        if (tstate == T2) begin
                            cw = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
                        end else begin
                            cw        = cw_bit(CW_A_OUT) | cw_bit(CW_RAM_WE);
                            last_step = 1'b1;
                        end
                    end
                    OP_LDI: begin
                        cw        = cw_bit(CW_IR_OUT) | cw_bit(CW_A_LOAD);
                        last_step = 1'b1;
                    end
                    OP_JMP: begin
                        cw        = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
                        last_step = 1'b1;
                    end
                    OP_JC: begin
                        cw        = cw_bit(CW_IR_OUT) | (cf ? cw_bit(CW_PC_LOAD) : '0);
                        last_step = 1'b1;
                    end
                    OP_JZ: begin
                        cw        = cw_bit(CW_IR_OUT) | (zf ? cw_bit(CW_PC_LOAD) : '0);
                        last_step = 1'b1;
                    end
`ifdef CTRL_EXT_JUMPS_EN
                    OP_JNC: begin
                        cw        = cw_bit(CW_IR_OUT) | (!cf ? cw_bit(CW_PC_LOAD) : '0);
                        last_step = 1'b1;
                    end
                    OP_JNZ: begin
                        cw        = cw_bit(CW_IR_OUT) | (!zf ? cw_bit(CW_PC_LOAD) : '0);
                        last_step = 1'b1;
                    end
`endif
                    OP_OUT: begin
                        cw        = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_LOAD);
                        last_step = 1'b1;
                    end
                    OP_HLT: enter_halt = 1'b1;
                    default: begin
                        if (HALT_ON_UNDEF) begin
                            enter_halt = 1'b1;
                        end else begin
                            last_step = 1'b1;
                        end
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control unit for the 8-bit accumulator CPU: T-state counter,
// halt latch and output gating. Optional macro: CTRL_EXT_JUMPS_EN (JNC/JNZ).
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W      = 4,
    parameter bit HALT_ON_UNDEF = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                cf,
    input  logic                zf,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                pc_out,
    output logic                mar_load,
    output logic                ram_out,
    output logic                ram_we,
    output logic                ir_load,
    output logic                ir_out,
    output logic                a_load,
    output logic                a_out,
    output logic                b_load,
    output logic                alu_out,
    output logic                alu_sub,
    output logic                flags_load,
    output logic                out_load,
    output logic                halted,
    output logic [2:0]          tstate
);

    tstate_e tstate_q, tstate_d;
    logic    halted_q, halted_d;
    cw_t     cw, cw_gated;
    logic    last_step, enter_halt;

    ctrl_decode #(
        .OPCODE_W      (OPCODE_W),
        .HALT_ON_UNDEF (HALT_ON_UNDEF)
    ) u_decode (
        .opcode     (ir_opcode),
        .tstate     (tstate_q),
        .cf         (cf),
        .zf         (zf),
        .cw         (cw),
        .last_step  (last_step),
        .enter_halt (enter_halt)
    );

    // Once halted the counter freezes at T2 until reset.
    always_comb begin
        tstate_d = tstate_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (enter_halt) begin
                halted_d = 1'b1;
            end else if (last_step) begin
                tstate_d = T0;
            end else begin
                tstate_d = tstate_e'(tstate_q + 3'd1);
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            tstate_q <= T0;
            halted_q <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            halted_q <= halted_d;
        end
    end

    // rst is also applied combinationally so outputs are quiet from the
    // first cycle it is high, before the synchronous reset has taken effect.
    assign cw_gated   = (rst || halted_q) ? '0 : cw;

    assign pc_inc     = cw_gated[CW_PC_INC];
    assign pc_load    = cw_gated[CW_PC_LOAD];
    assign pc_out     = cw_gated[CW_PC_OUT];
    assign mar_load   = cw_gated[CW_MAR_LOAD];
    assign ram_out    = cw_gated[CW_RAM_OUT];
    assign ram_we     = cw_gated[CW_RAM_WE];
    assign ir_load    = cw_gated[CW_IR_LOAD];
    assign ir_out     = cw_gated[CW_IR_OUT];
    assign a_load     = cw_gated[CW_A_LOAD];
    assign a_out      = cw_gated[CW_A_OUT];
    assign b_load     = cw_gated[CW_B_LOAD];
    assign alu_out    = cw_gated[CW_ALU_OUT];
    assign alu_sub    = cw_gated[CW_ALU_SUB];
    assign flags_load = cw_gated[CW_FLAGS_LOAD];
    assign out_load   = cw_gated[CW_OUT_LOAD];
    assign halted     = halted_q & ~rst;
    assign tstate     = rst ? 3'd0 : tstate_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them and checks bus exclusivity.
module tb_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ir_opcode;
    logic       cf, zf;
    logic       pc_inc, pc_load, pc_out, mar_load, ram_out, ram_we, ir_load, ir_out;
    logic       a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halted;
    logic [2:0] tstate;

    always #5 clk = ~clk;

    ctrl_sequencer #(
        .OPCODE_W      (4),
        .HALT_ON_UNDEF (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ir_opcode  (ir_opcode),
        .cf         (cf),
        .zf         (zf),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .pc_out     (pc_out),
        .mar_load   (mar_load),
        .ram_out    (ram_out),
        .ram_we     (ram_we),
        .ir_load    (ir_load),
        .ir_out     (ir_out),
        .a_load     (a_load),
        .a_out      (a_out),
        .b_load     (b_load),
        .alu_out    (alu_out),
        .alu_sub    (alu_sub),
        .flags_load (flags_load),
        .out_load   (out_load),
        .halted     (halted),
        .tstate     (tstate)
    );

    localparam logic [14:0] PC_INC   = 15'h4000;
    localparam logic [14:0] PC_LOAD  = 15'h2000;
    localparam logic [14:0] PC_OUT   = 15'h1000;
    localparam logic [14:0] MAR      = 15'h0800;
    localparam logic [14:0] RAM_OUT  = 15'h0400;
    localparam logic [14:0] RAM_WE   = 15'h0200;
    localparam logic [14:0] IR_LOAD  = 15'h0100;
    localparam logic [14:0] IR_OUT   = 15'h0080;
    localparam logic [14:0] A_LOAD   = 15'h0040;
    localparam logic [14:0] A_OUT    = 15'h0020;
    localparam logic [14:0] B_LOAD   = 15'h0010;
    localparam logic [14:0] ALU_OUT  = 15'h0008;
    localparam logic [14:0] ALU_SUB  = 15'h0004;
    localparam logic [14:0] FLAGS    = 15'h0002;
    localparam logic [14:0] OUT_LOAD = 15'h0001;
    localparam logic [14:0] NONE     = 15'h0000;

    typedef struct packed {
        logic [14:0] cw;
        logic        halted;
        logic [2:0]  ts;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    obs_t  act;
    obs_t  exp_v;
    string exp_n;

    assign act = {pc_inc, pc_load, pc_out, mar_load, ram_out, ram_we, ir_load, ir_out,
                  a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load,
                  halted, tstate};

    always @(negedge clk) begin
        checks++;
        if ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1) begin
            errors++;
            $display("FAIL bus_exclusive t=%0t drivers=%b required at most one high",
                     $time, {pc_out, ram_out, ir_out, a_out, alu_out});
        end
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            exp_n = name_q.pop_front();
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL %s t=%0t actual cw=%h halted=%b tstate=%0d required cw=%h halted=%b tstate=%0d",
                         exp_n, $time, act.cw, act.halted, act.ts, exp_v.cw, exp_v.halted, exp_v.ts);
            end
        end
    end

    task automatic step(input string nm, input logic [14:0] cw, input logic h, input logic [2:0] ts);
        exp_q.push_back(obs_t'({cw, h, ts}));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string nm);
        step({nm, ".T0"}, PC_OUT | MAR, 1'b0, 3'd0);
        step({nm, ".T1"}, RAM_OUT | IR_LOAD | PC_INC, 1'b0, 3'd1);
    endtask

    task automatic rst_pulse(input string nm);
        rst = 1'b1;
        step({nm, ".rst"}, NONE, 1'b0, 3'd0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t bench did not complete", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        ir_opcode = 4'h0;
        cf        = 1'b0;
        zf        = 1'b0;
        @(posedge clk);
        #1;
        step("reset0", NONE, 1'b0, 3'd0);
        step("reset1", NONE, 1'b0, 3'd0);
        rst = 1'b0;

        ir_opcode = 4'h5;
        fetch("ldi");
        step("ldi.T2", IR_OUT | A_LOAD, 1'b0, 3'd2);

        ir_opcode = 4'h2;
        fetch("add");
        step("add.T2", IR_OUT | MAR, 1'b0, 3'd2);
        step("add.T3", RAM_OUT | B_LOAD, 1'b0, 3'd3);
        step("add.T4", ALU_OUT | A_LOAD | FLAGS, 1'b0, 3'd4);

        ir_opcode = 4'h3;
        fetch("sub");
        step("sub.T2", IR_OUT | MAR, 1'b0, 3'd2);
        step("sub.T3", RAM_OUT | B_LOAD | ALU_SUB, 1'b0, 3'd3);
        step("sub.T4", ALU_OUT | A_LOAD | FLAGS | ALU_SUB, 1'b0, 3'd4);

        cf = 1'b1;
        ir_opcode = 4'h7;
        fetch("jc_taken");
        step("jc_taken.T2", IR_OUT | PC_LOAD, 1'b0, 3'd2);
        cf = 1'b0;
        fetch("jc_not");
        step("jc_not.T2", IR_OUT, 1'b0, 3'd2);

        zf = 1'b1;
        ir_opcode = 4'h8;
        fetch("jz_taken");
        step("jz_taken.T2", IR_OUT | PC_LOAD, 1'b0, 3'd2);
        zf = 1'b0;
        fetch("jz_not");
        step("jz_not.T2", IR_OUT, 1'b0, 3'd2);

        ir_opcode = 4'h1;
        fetch("lda");
        step("lda.T2", IR_OUT | MAR, 1'b0, 3'd2);
        step("lda.T3", RAM_OUT | A_LOAD, 1'b0, 3'd3);

        ir_opcode = 4'h4;
        fetch("sta");
        step("sta.T2", IR_OUT | MAR, 1'b0, 3'd2);
        step("sta.T3", A_OUT | RAM_WE, 1'b0, 3'd3);

        ir_opcode = 4'h6;
        fetch("jmp");
        step("jmp.T2", IR_OUT | PC_LOAD, 1'b0, 3'd2);

        ir_opcode = 4'hE;
        fetch("out");
        step("out.T2", A_OUT | OUT_LOAD, 1'b0, 3'd2);

        ir_opcode = 4'h0;
        fetch("nop");
        step("nop.T2", NONE, 1'b0, 3'd2);

        // Abort a store in T3: the write strobe must never appear.
        ir_opcode = 4'h4;
        fetch("sta_abort");
        step("sta_abort.T2", IR_OUT | MAR, 1'b0, 3'd2);
        rst = 1'b1;
        step("sta_abort.rst_T3", NONE, 1'b0, 3'd0);
        step("sta_abort.rst_hold", NONE, 1'b0, 3'd0);
        rst = 1'b0;
        ir_opcode = 4'h5;
        fetch("after_abort");
        step("after_abort.T2", IR_OUT | A_LOAD, 1'b0, 3'd2);

        cf = 1'b0;
        ir_opcode = 4'h9;
        fetch("op9");
`ifdef CTRL_EXT_JUMPS_EN
        step("jnc.T2", IR_OUT | PC_LOAD, 1'b0, 3'd2);
        step("jnc.back_T0", PC_OUT | MAR, 1'b0, 3'd0);
`else
        step("undef9.T2", NONE, 1'b0, 3'd2);
        for (int i = 0; i < 3; i++) begin
            step("undef9.halted", NONE, 1'b1, 3'd2);
        end
`endif
        rst_pulse("op9");

        ir_opcode = 4'hF;
        fetch("hlt");
        step("hlt.T2", NONE, 1'b0, 3'd2);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                ir_opcode = 4'h2;
                cf        = 1'b1;
                zf        = 1'b1;
            end
            step("hlt.halted", NONE, 1'b1, 3'd2);
        end
        rst_pulse("hlt");
        ir_opcode = 4'h5;
        fetch("resume");
        step("resume.T2", IR_OUT | A_LOAD, 1'b0, 3'd2);
        step("resume.back_T0", PC_OUT | MAR, 1'b0, 3'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
